// File: rtl/multi_channel_buffer.sv
// Multi-channel input buffer: one small FIFO per producer channel, drained onto a
// single output port by a round-robin arbiter whose grant is held across stalls.
module multi_channel_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNELS-1:0]                    in_valid,
  input  logic [CHANNELS*WIDTH-1:0]              in_data,
  output logic [CHANNELS-1:0]                    in_ready,
  output logic                                   out_valid,
  output logic [WIDTH-1:0]                       out_data,
  output logic [$clog2(CHANNELS)-1:0]            out_chan,
  input  logic                                   out_ready,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CHANNELS);

  logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
  logic [AW-1:0]       wr_ptr [CHANNELS];
  logic [AW-1:0]       rd_ptr [CHANNELS];
  logic [LW-1:0]       cnt    [CHANNELS];

  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] pop;

  logic [CW-1:0]       rr;
  logic [CW-1:0]       lock_chan;
  logic                locked;
  logic [CW-1:0]       rr_pick;
  logic [CW-1:0]       scan;
  logic                found;
  logic [CW-1:0]       grant;
  logic                xfer;

  // Status is derived from registered occupancy only, so a same-cycle pop
  // never opens in_ready on a full channel.
  always_comb begin
    nonempty = '0;
    in_ready = '0;
    level    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      nonempty[k]          = (cnt[k] != '0);
      in_ready[k]          = (cnt[k] != LW'(DEPTH));
      level[k*LW +: LW]    = cnt[k];
    end
  end

  assign out_valid = |nonempty;

  always_comb begin
    rr_pick = rr;
    scan    = rr;
    found   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      scan = rr + CW'(i);
      if (!found && nonempty[scan]) begin
        rr_pick = scan;
        found   = 1'b1;
      end
    end
  end

  // A stalled grant stays on its channel; that channel cannot drain without a
  // transfer, so the held head word stays valid.
  assign grant    = locked ? lock_chan : rr_pick;
  assign xfer     = out_valid & out_ready;
  assign out_chan = grant;
  assign out_data = mem[grant][rd_ptr[grant]];

  always_comb begin
    wr_en = '0;
    pop   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_en[k] = in_valid[k] & in_ready[k];
      pop[k]   = xfer & (grant == CW'(k));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_en[k]) begin
        mem[k][wr_ptr[k]] <= in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      rr        <= '0;
      locked    <= 1'b0;
      lock_chan <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_en[k]) begin
          wr_ptr[k] <= wr_ptr[k] + AW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        end
        if (wr_en[k] && !pop[k]) begin
          cnt[k] <= cnt[k] + LW'(1);
        end else if (!wr_en[k] && pop[k]) begin
          cnt[k] <= cnt[k] - LW'(1);
        end
      end
      if (xfer) begin
        rr     <= grant + CW'(1);
        locked <= 1'b0;
      end else if (out_valid) begin
        locked    <= 1'b1;
        lock_chan <= grant;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_buffer.sv
// Directed bench for multi_channel_buffer at WIDTH=8, DEPTH=4, CHANNELS=2.
module tb_multi_channel_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_chan;
  logic        out_ready;
  logic [5:0]  level;

  int total = 0;
  int bad   = 0;

  multi_channel_buffer #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_chan(out_chan), .out_ready(out_ready), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  function automatic logic [2:0] lvl(input int ch);
    return level[ch*3 +: 3];
  endfunction

  task automatic test_reset;
    rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick; tick;
    total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL rst_in_ready got=%b exp=11", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_chan !== 1'b0) begin bad++; $display("FAIL rst_out_chan got=%b exp=0", out_chan); end
    total++; if (level !== 6'd0) begin bad++; $display("FAIL rst_level got=%h exp=0", level); end
    rst = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0 || level !== 6'd0 || in_ready !== 2'b11) begin
      bad++; $display("FAIL post_rst got ov=%b lvl=%h rdy=%b exp ov=0 lvl=0 rdy=11", out_valid, level, in_ready); end
  endtask

  task automatic test_single;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    out_ready = 1'b1;
    in_valid = 2'b01; set_data(0, exp_d[0]);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i < 2) set_data(0, exp_d[i+1]); else in_valid = 2'b00;
      total++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_chan !== 1'b0) begin
        bad++; $display("FAIL single_word%0d got ov=%b d=%h ch=%b exp ov=1 d=%h ch=0", i, out_valid, out_data, out_chan, exp_d[i]); end
    end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_full;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hC1; exp_d[1] = 8'hC2; exp_d[2] = 8'hC3; exp_d[3] = 8'hC5;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 2'b10; set_data(1, 8'hC0 + 8'(i));
      tick;
      total++; if (lvl(1) !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
        bad++; $display("FAIL full_level%0d got=%0d exp=%0d", i, lvl(1), (i < 4) ? i + 1 : 4); end
    end
    total++; if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready[1]); end
    total++; if (out_chan !== 1'b1 || out_data !== 8'hC0) begin
      bad++; $display("FAIL full_head got ch=%b d=%h exp ch=1 d=c0", out_chan, out_data); end
    set_data(1, 8'hC5); out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (lvl(1) !== 3'd3 || in_ready[1] !== 1'b1) begin
      bad++; $display("FAIL full_pop_cycle got lvl=%0d rdy=%b exp lvl=3 rdy=1", lvl(1), in_ready[1]); end
    tick;
    in_valid = 2'b00;
    total++; if (lvl(1) !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", lvl(1)); end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      total++; if (out_data !== exp_d[j] || out_chan !== 1'b1) begin
        bad++; $display("FAIL full_drain%0d got d=%h ch=%b exp d=%h ch=1", j, out_data, out_chan, exp_d[j]); end
      tick;
    end
    total++; if (out_valid !== 1'b0 || level !== 6'd0) begin
      bad++; $display("FAIL full_empty got ov=%b lvl=%h exp ov=0 lvl=0", out_valid, level); end
  endtask

  task automatic test_fair;
    logic [7:0] exp_v;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 2'b11; set_data(0, 8'hA0 + 8'(i)); set_data(1, 8'hB0 + 8'(i));
      tick;
    end
    in_valid = 2'b00;
    total++; if (level !== 6'b100_100) begin bad++; $display("FAIL fair_levels got=%b exp=100100", level); end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_v = ((j % 2) != 0) ? (8'hB0 + 8'(j / 2)) : (8'hA0 + 8'(j / 2));
      total++; if (out_chan !== 1'(j % 2) || out_data !== exp_v) begin
        bad++; $display("FAIL fair_word%0d got ch=%b d=%h exp ch=%0d d=%h", j, out_chan, out_data, j % 2, exp_v); end
      tick;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid = 2'b10; set_data(1, 8'h55);
    tick;
    in_valid = 2'b01; set_data(0, 8'h66);
    for (int c = 0; c < 3; c++) begin
      total++; if (out_chan !== 1'b1 || out_data !== 8'h55) begin
        bad++; $display("FAIL stall_hold%0d got ch=%b d=%h exp ch=1 d=55", c, out_chan, out_data); end
      tick;
      in_valid = 2'b00;
    end
    out_ready = 1'b1;
    total++; if (out_chan !== 1'b1 || out_data !== 8'h55) begin
      bad++; $display("FAIL stall_release got ch=%b d=%h exp ch=1 d=55", out_chan, out_data); end
    tick;
    total++; if (out_valid !== 1'b1 || out_chan !== 1'b0 || out_data !== 8'h66) begin
      bad++; $display("FAIL stall_next got ov=%b ch=%b d=%h exp ov=1 ch=0 d=66", out_valid, out_chan, out_data); end
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_concurrent;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 2'b01; set_data(0, 8'hD0 + 8'(i));
      tick;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 2'b01; set_data(0, 8'hD2 + 8'(i));
      total++; if (lvl(0) !== 3'd2 || out_data !== 8'hD0 + 8'(i)) begin
        bad++; $display("FAIL conc_step%0d got lvl=%0d d=%h exp lvl=2 d=%h", i, lvl(0), out_data, 8'hD0 + 8'(i)); end
      tick;
    end
    in_valid = 2'b00;
    for (int i = 8; i < 10; i++) begin
      total++; if (out_data !== 8'hD0 + 8'(i)) begin
        bad++; $display("FAIL conc_tail%0d got=%h exp=%h", i, out_data, 8'hD0 + 8'(i)); end
      tick;
    end
    total++; if (out_valid !== 1'b0 || lvl(0) !== 3'd0) begin
      bad++; $display("FAIL conc_empty got ov=%b lvl=%0d exp ov=0 lvl=0", out_valid, lvl(0)); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b01; set_data(0, 8'hE0 + 8'(i));
      tick;
    end
    in_valid = 2'b00;
    total++; if (lvl(0) !== 3'd3) begin bad++; $display("FAIL mid_prefill got=%0d exp=3", lvl(0)); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || level !== 6'd0 || in_ready !== 2'b11 || out_chan !== 1'b0) begin
      bad++; $display("FAIL mid_async got ov=%b lvl=%h rdy=%b ch=%b exp ov=0 lvl=0 rdy=11 ch=0", out_valid, level, in_ready, out_chan); end
    tick;
    rst = 1'b1;
    in_valid = 2'b01; set_data(0, 8'h7E);
    tick;
    in_valid = 2'b00;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h7E || lvl(0) !== 3'd1) begin
      bad++; $display("FAIL mid_first got ov=%b d=%h lvl=%0d exp ov=1 d=7e lvl=1", out_valid, out_data, lvl(0)); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drained got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_full;
    test_fair;
    test_stall;
    test_concurrent;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_buffer.md
MULTI_CHANNEL_BUFFER -- requirements
Module: multi_channel_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per word.
REQ-002 The block SHALL have parameter DEPTH, default 4, entries per channel FIFO; power of two, at least 2.
REQ-003 The block SHALL have parameter CHANNELS, default 2, number of producer channels; power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, CHANNELS, per-channel write request.
REQ-007 The block SHALL have port in_data, input, CHANNELS*WIDTH, per-channel write word; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_ready, output, CHANNELS, per-channel "FIFO not full".
REQ-009 The block SHALL have port out_valid, output, 1, a word is presented.
REQ-010 The block SHALL have port out_data, output, WIDTH, presented word.
REQ-011 The block SHALL have port out_chan, output, log2(CHANNELS), source channel of out_data.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the word.
REQ-013 The block SHALL have port level, output, CHANNELS*(log2(DEPTH)+1), per-channel occupancy 0..DEPTH.

Function
REQ-014 Each channel SHALL own an independent DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy counter; pointers wrap modulo DEPTH.
REQ-015 A write to channel k SHALL occur on a rising edge with in_valid[k]=1 and in_ready[k]=1; words with in_valid[k]=1 and in_ready[k]=0 are not stored and are not counted.
REQ-016 in_ready[k] SHALL equal (level[k] < DEPTH), derived from registered state only; a read of channel k in the same cycle SHALL NOT raise in_ready[k] (no pass-through when full).
REQ-017 A word written at edge t SHALL be eligible for output from edge t onward (out_valid visible in cycle t+1); there SHALL be no empty-FIFO bypass.
REQ-018 out_valid SHALL be 1 when any channel is non-empty; out_data and out_chan SHALL be the head word and index of the granted channel.
REQ-019 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1; it pops one word from the granted channel.
REQ-020 Arbitration SHALL be round-robin: a registered pointer rr (reset 0) selects the first non-empty channel scanning rr, rr+1, ... modulo CHANNELS; after a transfer from channel g, rr SHALL become (g+1) mod CHANNELS.
REQ-021 While out_valid=1 and out_ready=0 the grant SHALL be locked: out_chan and out_data SHALL remain unchanged on following cycles until the transfer, regardless of writes to other channels.
REQ-022 A simultaneous write and pop on the same channel SHALL leave level unchanged and advance both pointers.
REQ-023 level[k] SHALL be incremented on a write only, decremented on a pop only, and never exceed DEPTH or fall below 0.
REQ-024 Words from each channel SHALL leave in the order written; there SHALL be no ordering guarantee across channels beyond REQ-020.

Reset
REQ-025 While rst=0, all pointers, levels and rr SHALL be 0 and the grant lock SHALL be cleared, asynchronously.
REQ-026 During and after reset: in_ready all 1, out_valid 0, out_chan 0, level all 0; out_data is a don't-care while out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; the first word written after release SHALL be the first word output for its channel.

Verification
REQ-028 Single channel: write 0x11,0x22,0x33 on channel 0, out_ready=1 -> out_data 0x11,0x22,0x33 with out_chan=0, first out_valid one cycle after first write.
REQ-029 Full: write 5 words on channel 1 with out_ready=0 (DEPTH=4) -> level[1]=4, in_ready[1]=0 after the 4th, 5th word dropped; then pop with write held -> in_ready[1] stays 0 during the pop cycle, rises next cycle.
REQ-030 Fairness: both channels pre-filled with 4 words (ch0 0xA0..0xA3, ch1 0xB0..0xB3), out_ready=1 -> out_chan 0,1,0,1,... data 0xA0,0xB0,0xA1,0xB1,...
REQ-031 Stall lock: ch1 only has 0x55 (rr=0), out_ready=0 for 3 cycles while 0x66 written to ch0 -> out_chan=1, out_data=0x55 held; on out_ready=1, 0x55 pops, then 0x66 presented.
REQ-032 Concurrent write/pop on channel 0 at level 2 -> level stays 2, order preserved across pointer wrap over 10 words.
REQ-033 Reset mid-stream: rst=0 with level 3 on ch0 -> out_valid=0, level 0 immediately (no clock edge needed); post-release write 0x7E -> first output 0x7E.
